// File: rtl/matvec_loader.sv
// matvec_loader: fetches ROWS matrix words plus one vector word, unpacks
// them byte-serially into the operand FIFOs, then runs matvec_mult once.
module matvec_loader #(
  parameter int ADDR_W = 32,
  parameter int ROWS   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  input  logic              mem_waitrequest,
  input  logic [63:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  output logic [ROWS:0]     fifo_wr_en,
  output logic [7:0]        fifo_wr_data,
  input  logic [ROWS:0]     fifo_full,
  output logic              mac_clr,
  output logic              mv_start,
  input  logic              mv_done,
  output logic              busy,
  output logic              complete
);

  localparam int IDX_W = $clog2(ROWS + 1);
  localparam int CNT_W = $clog2(ROWS);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    REQ,
    WAIT_DATA,
    UNPACK,
    START,
    WAIT_DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  word_idx;
  logic [CNT_W-1:0]  byte_cnt;
  logic [63:0]       data_q;

  logic wr_ok;
  logic last_byte;
  logic last_word;
  logic accept;

  // The current target FIFO can take a byte; word_idx never exceeds ROWS.
  assign wr_ok     = !fifo_full[word_idx];
  assign last_byte = byte_cnt == CNT_W'(ROWS - 1);
  assign last_word = word_idx == IDX_W'(ROWS);
  assign accept    = !mem_waitrequest;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state logic; go is only looked at in IDLE, so it is ignored while busy.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:      if (go) nxt = CLR;
      CLR:       nxt = REQ;
      REQ:       if (accept) nxt = WAIT_DATA;
      WAIT_DATA: if (mem_readdatavalid) nxt = UNPACK;
      UNPACK: begin
        if (wr_ok && last_byte) nxt = last_word ? START : REQ;
      end
      START:     nxt = WAIT_DONE;
      WAIT_DONE: if (mv_done) nxt = IDLE;
      default:   nxt = IDLE;
    endcase
  end

  // Datapath: base latch, word/byte counters and the captured read word.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      data_q   <= '0;
    end else begin
      unique case (state)
        IDLE: if (go) base_q <= base_addr;
        CLR:  word_idx <= '0;
        WAIT_DATA: begin
          if (mem_readdatavalid) begin
            data_q   <= mem_readdata;
            byte_cnt <= '0;
          end
        end
        UNPACK: begin
          if (wr_ok) begin
            byte_cnt <= byte_cnt + 1'b1;
            if (last_byte && !last_word) word_idx <= word_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: decoded from state, with the FIFO strobe gated by full.
  always_comb begin
    mem_address  = '0;
    mem_read     = 1'b0;
    fifo_wr_en   = '0;
    fifo_wr_data = '0;
    mac_clr      = 1'b0;
    mv_start     = 1'b0;
    busy         = state != IDLE;
    complete     = 1'b0;
    unique case (state)
      CLR: mac_clr = 1'b1;
      REQ: begin
        mem_read    = 1'b1;
        mem_address = base_q + {{(ADDR_W - IDX_W){1'b0}}, word_idx};
      end
      UNPACK: begin
        if (wr_ok) begin
          fifo_wr_en   = (ROWS + 1)'(1) << word_idx;
          fifo_wr_data = data_q[{byte_cnt, 3'b000} +: 8];
        end
      end
      START:     mv_start = 1'b1;
      WAIT_DONE: complete = mv_done;
      default: ;
    endcase
  end

endmodule
